// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the TURTLE fetch-stage PC generator.
//   pc_sel_e             - next-PC source select encoding
//   MTVEC_MODE_DIRECT    - mtvec[1:0] value for direct trap mode
//   MTVEC_MODE_VECTORED  - mtvec[1:0] value for vectored trap mode
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_SEQ    = 3'd1,
    PC_JAL    = 3'd2,
    PC_JALR   = 3'd3,
    PC_BRANCH = 3'd4,
    PC_TRAP   = 3'd5,
    PC_MRET   = 3'd6,
    PC_RET    = 3'd7
  } pc_sel_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data as the new top (oldest entry lost when full)
//   pop         - discard top (no-op when empty)
//   replace     - overwrite top in place, count unchanged
//   push_data   - return address to store
//   top         - current top entry (combinational, meaningful when count>0)
//   count       - number of valid entries, saturates at DEPTH
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  logic [XLEN-1:0]          push_data,
  output logic [XLEN-1:0]          top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign ptr_inc = ptr + PW'(1);
  assign top     = mem[ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && !replace && count != '0) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Storage carries no reset; entries beyond count are never consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push)         mem[ptr_inc] <= push_data;
      else if (replace) mem[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
//   clk, reset            - clock, synchronous active-high reset
//   stall                 - hold PC (TRAP still proceeds)
//   pc_sel                - next-PC source (see pc_pkg::pc_sel_e)
//   inst_len16            - current instruction is 16-bit (C_EXT only)
//   is_call               - JAL/JALR/RET writes a link register: push RAS
//   alu_out               - JALR target before LSB clear
//   imm_j, imm_b          - jump / branch immediates
//   take_branch           - branch condition
//   csr_mtvec, csr_mepc   - trap vector / trap return PC
//   trap_irq, trap_cause  - trap kind and cause code
//   pc_out, pc_seq_out    - current PC and its fall-through link value
//   redirect              - last cycle committed a non-sequential PC
//   misaligned, bad_target- last attempted target faulted, and its value
//   ras_count             - valid RAS entries
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 'h4,
  parameter bit              C_EXT        = 1'b1,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   pc_sel,
  input  logic                         inst_len16,
  input  logic                         is_call,
  input  logic [XLEN-1:0]              alu_out,
  input  logic [XLEN-1:0]              imm_j,
  input  logic [XLEN-1:0]              imm_b,
  input  logic                         take_branch,
  input  logic [XLEN-1:0]              csr_mtvec,
  input  logic [XLEN-1:0]              csr_mepc,
  input  logic                         trap_irq,
  input  logic [4:0]                   trap_cause,
  output logic [XLEN-1:0]              pc_out,
  output logic [XLEN-1:0]              pc_seq_out,
  output logic                         redirect,
  output logic                         misaligned,
  output logic [XLEN-1:0]              bad_target,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  pc_sel_e         sel;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] target;
  logic            chk_align;
  logic            is_flow;
  logic            want_push, want_pop, want_replace;
  logic            target_bad;
  logic            active;
  logic            commit;
  logic            fault;
  logic            ras_nonempty;

  assign sel          = pc_sel_e'(pc_sel);
  assign step         = (C_EXT && inst_len16) ? XLEN'(2) : XLEN'(4);
  assign pc_seq_out   = pc_out + step;
  assign jalr_tgt     = alu_out & ~XLEN'(1);
  assign trap_base    = csr_mtvec & ~XLEN'(3);
  assign trap_tgt     = (csr_mtvec[1:0] == MTVEC_MODE_VECTORED && trap_irq)
                        ? trap_base + XLEN'({trap_cause, 2'b00}) : trap_base;
  assign ras_nonempty = (ras_count != '0);

  always_comb begin
    target       = pc_out;
    chk_align    = 1'b0;
    is_flow      = 1'b0;
    want_push    = 1'b0;
    want_pop     = 1'b0;
    want_replace = 1'b0;
    case (sel)
      PC_HOLD: target = pc_out;
      PC_SEQ:  target = pc_seq_out;
      PC_JAL: begin
        target    = pc_out + imm_j;
        chk_align = 1'b1;
        is_flow   = 1'b1;
        want_push = is_call;
      end
      PC_JALR: begin
        target    = jalr_tgt;
        chk_align = 1'b1;
        is_flow   = 1'b1;
        want_push = is_call;
      end
      PC_BRANCH: begin
        target    = take_branch ? pc_out + imm_b : pc_seq_out;
        chk_align = take_branch;
        is_flow   = take_branch;
      end
      PC_TRAP: begin
        target  = trap_tgt;
        is_flow = 1'b1;
      end
      PC_MRET: begin
        target  = csr_mepc;
        is_flow = 1'b1;
      end
      PC_RET: begin
        target    = ras_nonempty ? ras_top : jalr_tgt;
        chk_align = 1'b1;
        is_flow   = 1'b1;
        // A RET that also links behaves as pop-then-push.
        want_pop     = !is_call && ras_nonempty;
        want_replace = is_call && ras_nonempty;
        want_push    = is_call && !ras_nonempty;
      end
      default: target = pc_out;
    endcase
  end

  assign target_bad = chk_align && (C_EXT ? target[0] : (target[1:0] != 2'b00));
  assign active     = (sel == PC_TRAP) || !stall;
  assign fault      = active && target_bad;
  assign commit     = active && !target_bad;

  pc_ras #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (commit && want_push),
    .pop       (commit && want_pop),
    .replace   (commit && want_replace),
    .push_data (pc_seq_out),
    .top       (ras_top),
    .count     (ras_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= RESET_VECTOR;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      bad_target <= '0;
    end else begin
      redirect   <= commit && is_flow;
      misaligned <= fault;
      if (fault)  bad_target <= target;
      if (commit) pc_out     <= target;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, inst_len16, is_call, take_branch, trap_irq;
  logic [2:0]  pc_sel;
  logic [31:0] alu_out, imm_j, imm_b, csr_mtvec, csr_mepc;
  logic [4:0]  trap_cause;

  // index 0: C_EXT=0 instance, index 1: C_EXT=1 instance
  logic [31:0] o_pc [2];
  logic [31:0] o_seq [2];
  logic        o_red [2];
  logic        o_mis [2];
  logic [31:0] o_bad [2];
  logic [2:0]  o_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model state (RAS kept oldest-first as a plain list)
  logic [31:0] m_pc [2], n_pc [2];
  logic        m_red [2], n_red [2];
  logic        m_mis [2], n_mis [2];
  logic [31:0] m_bad [2], n_bad [2];
  logic [31:0] m_ras [2][4], n_ras [2][4];
  int          m_cnt [2], n_cnt [2];

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h4), .C_EXT(1'b0), .RAS_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .inst_len16(inst_len16),
    .is_call(is_call), .alu_out(alu_out), .imm_j(imm_j), .imm_b(imm_b),
    .take_branch(take_branch), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .trap_irq(trap_irq), .trap_cause(trap_cause), .pc_out(o_pc[0]), .pc_seq_out(o_seq[0]),
    .redirect(o_red[0]), .misaligned(o_mis[0]), .bad_target(o_bad[0]), .ras_count(o_cnt[0]));

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h4), .C_EXT(1'b1), .RAS_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .inst_len16(inst_len16),
    .is_call(is_call), .alu_out(alu_out), .imm_j(imm_j), .imm_b(imm_b),
    .take_branch(take_branch), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .trap_irq(trap_irq), .trap_cause(trap_cause), .pc_out(o_pc[1]), .pc_seq_out(o_seq[1]),
    .redirect(o_red[1]), .misaligned(o_mis[1]), .bad_target(o_bad[1]), .ras_count(o_cnt[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_seq(input int k);
    return m_pc[k] + ((k == 1 && inst_len16) ? 32'd2 : 32'd4);
  endfunction

  task automatic ras_push(input int k, input logic [31:0] v);
    if (n_cnt[k] == 4) begin
      for (int i = 0; i < 3; i++) n_ras[k][i] = n_ras[k][i+1];
      n_ras[k][3] = v;
    end else begin
      n_ras[k][n_cnt[k]] = v;
      n_cnt[k]++;
    end
  endtask

  task automatic model_next(input int k);
    logic [31:0] seq, tgt, base;
    bit c, chk, bad;
    c = (k == 1);
    n_pc[k] = m_pc[k]; n_bad[k] = m_bad[k]; n_cnt[k] = m_cnt[k];
    for (int i = 0; i < 4; i++) n_ras[k][i] = m_ras[k][i];
    n_red[k] = 1'b0; n_mis[k] = 1'b0;
    seq = m_seq(k);
    if (reset) begin
      n_pc[k] = 32'h4; n_cnt[k] = 0; n_bad[k] = 32'h0;
    end else if (pc_sel == PC_TRAP) begin
      base = {csr_mtvec[31:2], 2'b00};
      n_pc[k] = (csr_mtvec[1:0] == 2'b01 && trap_irq) ? base + 32'(trap_cause) * 4 : base;
      n_red[k] = 1'b1;
    end else if (!stall && pc_sel != PC_HOLD) begin
      chk = 1'b1;
      tgt = seq;
      case (pc_sel)
        PC_SEQ:    chk = 1'b0;
        PC_JAL:    tgt = m_pc[k] + imm_j;
        PC_JALR:   tgt = {alu_out[31:1], 1'b0};
        PC_BRANCH: begin chk = take_branch; tgt = take_branch ? m_pc[k] + imm_b : seq; end
        PC_MRET:   begin chk = 1'b0; tgt = csr_mepc; end
        default:   tgt = (m_cnt[k] > 0) ? m_ras[k][m_cnt[k]-1] : {alu_out[31:1], 1'b0};
      endcase
      bad = chk && (c ? tgt[0] : (tgt[1:0] != 2'b00));
      if (bad) begin
        n_mis[k] = 1'b1; n_bad[k] = tgt;
      end else begin
        n_pc[k] = tgt;
        n_red[k] = !(pc_sel == PC_SEQ || (pc_sel == PC_BRANCH && !take_branch));
        if ((pc_sel == PC_JAL || pc_sel == PC_JALR) && is_call) ras_push(k, seq);
        if (pc_sel == PC_RET) begin
          if (m_cnt[k] > 0) n_cnt[k]--;
          if (is_call) ras_push(k, seq);
        end
      end
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) model_next(k);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = n_pc[k]; m_red[k] = n_red[k]; m_mis[k] = n_mis[k];
      m_bad[k] = n_bad[k]; m_cnt[k] = n_cnt[k];
      for (int i = 0; i < 4; i++) m_ras[k][i] = n_ras[k][i];
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; pc_sel = PC_HOLD; inst_len16 = 0; is_call = 0;
    take_branch = 0; trap_irq = 0; trap_cause = 0; alu_out = 0; imm_j = 0; imm_b = 0;
    csr_mtvec = 0; csr_mepc = 0;
  endtask

  // literal expectation pinned on both the DUT and the model
  task automatic lit_pc(input string name, input int k, input logic [31:0] exp);
    check(name, o_pc[k], exp);
    check({name, "_model"}, m_pc[k], exp);
  endtask

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("pc_out[%0d]", k), o_pc[k], m_pc[k]);
        check($sformatf("pc_seq_out[%0d]", k), o_seq[k], m_seq(k));
        check($sformatf("redirect[%0d]", k), 32'(o_red[k]), 32'(m_red[k]));
        check($sformatf("misaligned[%0d]", k), 32'(o_mis[k]), 32'(m_mis[k]));
        check($sformatf("bad_target[%0d]", k), o_bad[k], m_bad[k]);
        check($sformatf("ras_count[%0d]", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
      end
    end
  end

  initial begin
    logic [31:0] exp_ret [5];
    exp_ret[0] = 32'hCC; exp_ret[1] = 32'hBC; exp_ret[2] = 32'hAC;
    exp_ret[3] = 32'h9C; exp_ret[4] = 32'h300;

    idle(); reset = 1;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_red[k] = 0; m_mis[k] = 0; m_bad[k] = 0; m_cnt[k] = 0;
      for (int i = 0; i < 4; i++) m_ras[k][i] = 0;
    end
    cycle();
    chk_en = 1;
    idle();
    lit_pc("reset_pc", 1, 32'h4);
    check("reset_cnt", 32'(o_cnt[1]), 32'h0);

    pc_sel = PC_SEQ; inst_len16 = 1; cycle();
    lit_pc("seq16_c1", 1, 32'h6);
    lit_pc("seq16_c0", 0, 32'h8);
    inst_len16 = 0; cycle();
    lit_pc("seq32_c1", 1, 32'hA);

    pc_sel = PC_JALR; alu_out = 32'h100; cycle();
    lit_pc("jalr_0x100", 1, 32'h100);
    pc_sel = PC_JAL; imm_j = 32'h40; is_call = 1; cycle();
    lit_pc("jal_call", 1, 32'h140);
    check("jal_redirect", 32'(o_red[1]), 32'h1);
    check("jal_cnt", 32'(o_cnt[1]), 32'h1);
    pc_sel = PC_RET; is_call = 0; alu_out = 32'h0; cycle();
    lit_pc("ret_pc", 1, 32'h104);
    check("ret_cnt", 32'(o_cnt[1]), 32'h0);

    pc_sel = PC_JALR; alu_out = 32'h202; cycle();
    lit_pc("mis_hold_c0", 0, 32'h104);
    check("mis_flag_c0", 32'(o_mis[0]), 32'h1);
    check("mis_bad_c0", o_bad[0], 32'h202);
    check("mis_red_c0", 32'(o_red[0]), 32'h0);
    lit_pc("jalr_c1", 1, 32'h202);

    pc_sel = PC_TRAP; stall = 1; csr_mtvec = 32'h1001; trap_irq = 1; trap_cause = 7; cycle();
    lit_pc("trap_vec", 1, 32'h101C);
    lit_pc("trap_vec_c0", 0, 32'h101C);
    trap_irq = 0; cycle();
    lit_pc("trap_direct", 1, 32'h1000);
    stall = 0; pc_sel = PC_MRET; csr_mepc = 32'h88; cycle();
    lit_pc("mret", 1, 32'h88);

    pc_sel = PC_JAL; imm_j = 32'h10; is_call = 1;
    for (int i = 0; i < 5; i++) cycle();
    lit_pc("calls_pc", 1, 32'hD8);
    check("calls_cnt", 32'(o_cnt[1]), 32'h4);
    pc_sel = PC_RET; is_call = 0; alu_out = 32'h300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      lit_pc($sformatf("ret_seq%0d", i), 1, exp_ret[i]);
    end
    check("ret_empty_cnt", 32'(o_cnt[1]), 32'h0);

    pc_sel = PC_BRANCH; take_branch = 0; imm_b = 32'h80; cycle();
    lit_pc("branch_nt", 1, 32'h304);
    check("branch_nt_red", 32'(o_red[1]), 32'h0);
    pc_sel = PC_JAL; stall = 1; imm_j = 32'h40; cycle();
    lit_pc("stall_jal", 1, 32'h304);
    stall = 0; is_call = 1; cycle();
    lit_pc("jal_after_stall", 1, 32'h344);
    reset = 1; cycle();
    lit_pc("mid_reset", 1, 32'h4);
    check("mid_reset_cnt", 32'(o_cnt[1]), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      pc_sel      = 3'($urandom_range(0, 7));
      inst_len16  = 1'($urandom);
      is_call     = 1'($urandom);
      take_branch = 1'($urandom);
      alu_out     = $urandom & (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      imm_j       = $urandom & (($urandom_range(0, 1) == 0) ? 32'h0000_0FFC : 32'hFFFF_FFFF);
      imm_b       = $urandom & (($urandom_range(0, 1) == 0) ? 32'h0000_0FFE : 32'hFFFF_FFFF);
      csr_mtvec   = $urandom;
      csr_mepc    = $urandom;
      trap_irq    = 1'($urandom);
      trap_cause  = 5'($urandom);
      cycle();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
